// File: rtl/systolic_feeder.sv
// systolic_feeder: operand staging, diagonal skew generation and result
// capture around a 4x4 8-bit output-stationary systolic multiplier array.
//
// Ports:
//   i_clk, i_arst          clock, async active-high reset
//   i_opValid/o_opReady    operand handshake carrying i_a (A[row][k]) and
//                          i_b (B[k][col])
//   o_row, o_col           skewed streams, slot [x][0] consumed this cycle
//   o_arrayClr             registered one-cycle array clear pulse
//   i_c                    array accumulator outputs
//   o_resValid/i_resReady  result handshake carrying o_result (C = A*B)
//
// Parameter SETTLE: cycles waited after the last FEED cycle (>= 4).
// Macro SYSTOLIC_FEEDER_OPQUEUE_EN: adds a one-entry operand buffer so a
// new operand can be accepted while an operation is in flight.
module systolic_feeder #(
    parameter int SETTLE = 4
) (
    input  logic                    i_clk,
    input  logic                    i_arst,
    input  logic                    i_opValid,
    output logic                    o_opReady,
    input  logic [3:0][3:0][7:0]    i_a,
    input  logic [3:0][3:0][7:0]    i_b,
    output logic [3:0][6:0][7:0]    o_row,
    output logic [3:0][6:0][7:0]    o_col,
    output logic                    o_arrayClr,
    input  logic [3:0][3:0][15:0]   i_c,
    output logic                    o_resValid,
    input  logic                    i_resReady,
    output logic [3:0][3:0][15:0]   o_result
);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FEED,
        DRAIN,
        DONE
    } state_t;

    localparam logic [3:0] FEED_LAST  = 4'd6;
    localparam logic [3:0] DRAIN_LAST = 4'(SETTLE - 1);

    state_t state, state_nxt;
    logic [3:0] cnt, cnt_nxt;

    logic [3:0][3:0][7:0] op_a, op_b;
    logic [3:0][3:0][7:0] src_a, src_b;
    logic [3:0][6:0][7:0] skew_row, skew_col;

    logic accept;
    logic have_buf;
    logic op_load;
    logic res_cap;
    logic res_clr;

    assign accept = i_opValid & o_opReady;

`ifdef SYSTOLIC_FEEDER_OPQUEUE_EN
    logic                 buf_full;
    logic                 buf_wr;
    logic [3:0][3:0][7:0] buf_a, buf_b;

    assign o_opReady = ~buf_full;
    assign have_buf  = buf_full;
    // Operands taken while busy park in the buffer; IDLE takes them direct.
    assign buf_wr    = accept & (state != IDLE);
    assign src_a     = buf_full ? buf_a : i_a;
    assign src_b     = buf_full ? buf_b : i_b;

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            buf_full <= 1'b0;
            buf_a    <= '0;
            buf_b    <= '0;
        end else begin
            if (buf_wr) begin
                buf_a <= i_a;
                buf_b <= i_b;
            end
            buf_full <= buf_wr | (buf_full & ~op_load);
        end
    end
`else
    assign o_opReady = (state == IDLE);
    assign have_buf  = 1'b0;
    assign src_a     = i_a;
    assign src_b     = i_b;
`endif

    // Row i is delayed by i slots, column j by j slots, so PE[i][j]
    // meets A[i][k] and B[k][j] in the same cycle.
    always_comb begin
        skew_row = '0;
        skew_col = '0;
        for (int i = 0; i < 4; i++) begin
            for (int k = 0; k < 4; k++) begin
                skew_row[i][i + k] = op_a[i][k];
                skew_col[i][i + k] = op_b[k][i];
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        op_load   = 1'b0;
        res_cap   = 1'b0;
        res_clr   = 1'b0;
        unique case (state)
            IDLE: begin
                if (have_buf | accept) begin
                    op_load   = 1'b1;
                    state_nxt = CLEAR;
                end
            end
            CLEAR: begin
                cnt_nxt   = '0;
                state_nxt = FEED;
            end
            FEED: begin
                if (cnt == FEED_LAST) begin
                    cnt_nxt   = '0;
                    state_nxt = DRAIN;
                end else begin
                    cnt_nxt = cnt + 4'd1;
                end
            end
            DRAIN: begin
                if (cnt == DRAIN_LAST) begin
                    cnt_nxt   = '0;
                    res_cap   = 1'b1;
                    state_nxt = DONE;
                end else begin
                    cnt_nxt = cnt + 4'd1;
                end
            end
            DONE: begin
                if (i_resReady) begin
                    res_clr = 1'b1;
                    if (have_buf) begin
                        op_load   = 1'b1;
                        state_nxt = CLEAR;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            op_a       <= '0;
            op_b       <= '0;
            o_row      <= '0;
            o_col      <= '0;
            o_arrayClr <= 1'b0;
            o_result   <= '0;
            o_resValid <= 1'b0;
        end else begin
            if (op_load) begin
                op_a <= src_a;
                op_b <= src_b;
            end
            // op_load coincides with entry to CLEAR, so this is the
            // one-cycle clear pulse.
            o_arrayClr <= op_load;
            if (state == CLEAR) begin
                o_row <= skew_row;
                o_col <= skew_col;
            end else if (state == FEED) begin
                for (int i = 0; i < 4; i++) begin
                    o_row[i] <= {8'h00, o_row[i][6:1]};
                    o_col[i] <= {8'h00, o_col[i][6:1]};
                end
            end
            if (res_cap) begin
                o_result   <= i_c;
                o_resValid <= 1'b1;
            end else if (res_clr) begin
                o_resValid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_systolic_feeder.sv
// tb_systolic_feeder: directed + random checks of systolic_feeder against
// a behavioural array and plain matrix-multiply reference.
module tb_systolic_feeder;

    localparam int SETTLE = 4;

    typedef logic [3:0][3:0][7:0]  mat8_t;
    typedef logic [3:0][3:0][15:0] mat16_t;
    typedef logic [3:0][6:0][7:0]  strm_t;

    logic   clk = 1'b0;
    logic   rst = 1'b1;
    logic   op_valid = 1'b0;
    logic   res_ready = 1'b0;
    mat8_t  ma = '0;
    mat8_t  mb = '0;
    logic   op_ready;
    strm_t  row, col;
    logic   clr;
    mat16_t c;
    mat16_t result;
    logic   res_valid;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    systolic_feeder #(.SETTLE(SETTLE)) dut (
        .i_clk      (clk),
        .i_arst     (rst),
        .i_opValid  (op_valid),
        .o_opReady  (op_ready),
        .i_a        (ma),
        .i_b        (mb),
        .o_row      (row),
        .o_col      (col),
        .o_arrayClr (clr),
        .i_c        (c),
        .o_resValid (res_valid),
        .i_resReady (res_ready),
        .o_result   (result)
    );

    // Behavioural output-stationary array: A flows right, B flows down,
    // each PE accumulates the product of what arrives this cycle.
    logic [7:0]  a_r [4][4];
    logic [7:0]  b_r [4][4];
    logic [15:0] acc [4][4];

    function automatic logic [7:0] a_in(int i, int j);
        return (j == 0) ? row[i][0] : a_r[i][(j == 0) ? 0 : j - 1];
    endfunction

    function automatic logic [7:0] b_in(int i, int j);
        return (i == 0) ? col[j][0] : b_r[(i == 0) ? 0 : i - 1][j];
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst || clr) begin
            for (int i = 0; i < 4; i++)
                for (int j = 0; j < 4; j++) begin
                    a_r[i][j] <= '0;
                    b_r[i][j] <= '0;
                    acc[i][j] <= '0;
                end
        end else begin
            for (int i = 0; i < 4; i++)
                for (int j = 0; j < 4; j++) begin
                    a_r[i][j] <= a_in(i, j);
                    b_r[i][j] <= b_in(i, j);
                    acc[i][j] <= acc[i][j] +
                        16'(a_in(i, j)) * 16'(b_in(i, j));
                end
        end
    end

    always_comb begin
        c = '0;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                c[i][j] = acc[i][j];
    end

    function automatic mat16_t matmul(mat8_t x, mat8_t y);
        mat16_t r = '0;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                for (int k = 0; k < 4; k++)
                    r[i][j] = r[i][j] + 16'(x[i][k]) * 16'(y[k][j]);
        return r;
    endfunction

    function automatic mat8_t rand_mat();
        mat8_t m;
        for (int i = 0; i < 4; i++)
            for (int k = 0; k < 4; k++)
                m[i][k] = 8'($urandom_range(0, 255));
        return m;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string tag, logic [255:0] obs, logic [255:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Leaves the bench in the CLEAR cycle (accept + 1).
    task automatic start_op(input mat8_t x, input mat8_t y);
        ma = x;
        mb = y;
        op_valid = 1'b1;
        for (int k = 0; k < 60 && !op_ready; k++) tick();
        chk("op_ready", op_ready, 1'b1);
        tick();
        op_valid = 1'b0;
        chk("clr_on", clr, 1'b1);
    endtask

    task automatic wait_res(input mat16_t exp, input int lat);
        int k = 0;
        while (!res_valid && k < 60) begin
            tick();
            k++;
        end
        chk("res_valid", res_valid, 1'b1);
        if (lat >= 0) chk("latency", k, lat);
        chk("result", result, exp);
    endtask

    mat8_t  ta, tb2, a2, b2;
    mat16_t exp_r, exp2;
    strm_t  exp_row, exp_col;

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        // reset
        rst = 1'b1;
        repeat (2) tick();
        chk("rst_row", row, '0);
        chk("rst_col", col, '0);
        chk("rst_result", result, '0);
        chk("rst_valid", res_valid, 1'b0);
        chk("rst_clr", clr, 1'b0);
        rst = 1'b0;
        tick();
        chk("ready_after_rst", op_ready, 1'b1);

        // identity * (4k+j+1)
        res_ready = 1'b1;
        for (int i = 0; i < 4; i++)
            for (int k = 0; k < 4; k++) begin
                ta[i][k]  = (i == k) ? 8'd1 : 8'd0;
                tb2[i][k] = 8'(4 * i + k + 1);
            end
        start_op(ta, tb2);
        tick();
        chk("clr_one_cycle", clr, 1'b0);
        wait_res(matmul(ta, tb2), 11);
        chk("ident_elem23", result[2][3], 16'd12);
        tick();
        chk("valid_drop", res_valid, 1'b0);

        // all 0xFF
        ta  = {16{8'hFF}};
        tb2 = {16{8'hFF}};
        start_op(ta, tb2);
        wait_res(matmul(ta, tb2), 12);
        chk("ff_elem12", result[1][2], 16'hF804);
        tick();

        // stream shape at first FEED cycle
        for (int i = 0; i < 4; i++)
            for (int k = 0; k < 4; k++)
                ta[i][k] = 8'(16 * i + k);
        tb2 = rand_mat();
        for (int x = 0; x < 4; x++)
            for (int t = 0; t < 7; t++) begin
                exp_row[x][t] = (t - x >= 0 && t - x <= 3) ?
                                ta[x][t - x] : 8'h00;
                exp_col[x][t] = (t - x >= 0 && t - x <= 3) ?
                                tb2[t - x][x] : 8'h00;
            end
        start_op(ta, tb2);
        chk("clear_row_zero", row, '0);
        tick();
        chk("feed0_row", row, exp_row);
        chk("feed0_col", col, exp_col);
        chk("row00", row[0][0], 8'h00);
        chk("row11", row[1][1], 8'h10);
        chk("row36", row[3][6], 8'h33);
        chk("row3_low", row[3][2:0], 24'h0);
        tick();
        chk("feed1_row35", row[3][5], 8'h33);
        wait_res(matmul(ta, tb2), 10);
        tick();

        // hold result while not ready
        res_ready = 1'b0;
        ta  = rand_mat();
        tb2 = rand_mat();
        exp_r = matmul(ta, tb2);
        start_op(ta, tb2);
        wait_res(exp_r, 12);
        for (int h = 0; h < 5; h++) begin
            tick();
            chk("hold_result", result, exp_r);
            chk("hold_valid", res_valid, 1'b1);
`ifndef SYSTOLIC_FEEDER_OPQUEUE_EN
            chk("hold_not_ready", op_ready, 1'b0);
`endif
        end
        res_ready = 1'b1;
        tick();
        chk("release_valid", res_valid, 1'b0);
        chk("release_ready", op_ready, 1'b1);

        // back-to-back random ops
        for (int r = 0; r < 6; r++) begin
            ta  = rand_mat();
            tb2 = rand_mat();
            start_op(ta, tb2);
            wait_res(matmul(ta, tb2), 12);
        end

        // reset during FEED
        ta  = rand_mat();
        tb2 = rand_mat();
        start_op(ta, tb2);
        tick();
        tick();
        rst = 1'b1;
        #1;
        chk("arst_row", row, '0);
        chk("arst_col", col, '0);
        chk("arst_clr", clr, 1'b0);
        chk("arst_valid", res_valid, 1'b0);
        chk("arst_result", result, '0);
        tick();
        rst = 1'b0;
        tick();
        ta  = rand_mat();
        tb2 = rand_mat();
        start_op(ta, tb2);
        wait_res(matmul(ta, tb2), 12);
        tick();

`ifdef SYSTOLIC_FEEDER_OPQUEUE_EN
        // second op queued during DRAIN of the first
        ta  = rand_mat();
        tb2 = rand_mat();
        a2  = rand_mat();
        b2  = rand_mat();
        exp2 = matmul(a2, b2);
        start_op(ta, tb2);
        repeat (9) tick();
        ma = a2;
        mb = b2;
        op_valid = 1'b1;
        chk("q_ready", op_ready, 1'b1);
        tick();
        op_valid = 1'b0;
        wait_res(matmul(ta, tb2), 2);
        tick();
        chk("q_clr", clr, 1'b1);
        wait_res(exp2, 12);
        tick();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
